debounce_ff: RTL and testbench

DEBOUNCE_FF -- requirements
Module: debounce_ff

---
 rtl/debounce_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/debounce_ff.sv | 110 +++++++++++
 tb/tb_debounce_ff.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce_ff block.
package debounce_pkg;

  // Qualification FSM: Q is 0 in STABLE_LO/WAIT_HI and 1 in STABLE_HI/WAIT_LO.
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic CK,
  input  logic R,
  input  logic D,
  output logic Q
);

  logic meta;

  // Shift the raw level through two flops; the second stage is the only safe tap.
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_ff.sv
// Debouncer: synchronizes D, then accepts a level change only after
// DEBOUNCE_CYCLES+1 consecutive agreeing samples. Q, BUSY (and RISE/FALL)
// are all registered.
// Optional feature macro: DEBOUNCE_EDGE_EN adds one-cycle RISE/FALL pulses.
module debounce_ff
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic CK,
  input  logic R,
  input  logic D,
  output logic Q,
  output logic BUSY
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic RISE,
  output logic FALL
`endif
);

  // Counter value at which the next agreeing sample completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .CK (CK),
    .R  (R),
    .D  (D),
    .Q  (s)
  );

  // Qualification FSM with registered Q/BUSY/edge outputs. A disagreeing
  // sample during a WAIT state drops the candidate (glitch rejected) and
  // Q is left untouched. The counter stops at CNT_LAST so it never wraps.
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state <= STABLE_LO;
      cnt   <= '0;
      Q     <= 1'b0;
      BUSY  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
      RISE  <= 1'b0;
      FALL  <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_EDGE_EN
      RISE <= 1'b0;
      FALL <= 1'b0;
`endif
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            BUSY  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            Q     <= 1'b1;
            BUSY  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            RISE  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= '0;
            BUSY  <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= STABLE_HI;
            BUSY  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            Q     <= 1'b0;
            BUSY  <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            FALL  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          Q     <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_ff.sv
// Scoreboard bench for debounce_ff (DEBOUNCE_CYCLES=4). The driver applies D
// at each negedge and queues the expected outputs for after the next posedge;
// an independent monitor pops and compares shortly after every posedge.
module tb_debounce_ff;

  localparam int N = 4;

  logic CK = 1'b0;
  logic R  = 1'b0;
  logic D  = 1'b0;
  logic Q, BUSY;
`ifdef DEBOUNCE_EDGE_EN
  logic RISE, FALL;
`endif

  always #5 CK = ~CK;

  debounce_ff #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
    .CK   (CK),
    .R    (R),
    .D    (D),
    .Q    (Q),
    .BUSY (BUSY)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .RISE (RISE),
    .FALL (FALL)
`endif
  );

  typedef struct {
    logic  q;
    logic  b;
    logic  r;
    logic  f;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {Q,BUSY,RISE,FALL}=%b want %b", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_outs();
`ifdef DEBOUNCE_EDGE_EN
    return {Q, BUSY, RISE, FALL};
`else
    return {Q, BUSY, 2'b00};
`endif
  endfunction

  function automatic logic [3:0] exp_outs(input exp_t e);
`ifdef DEBOUNCE_EDGE_EN
    return {e.q, e.b, e.r, e.f};
`else
    return {e.q, e.b, 2'b00};
`endif
  endfunction

  // Monitor: one expectation per clock edge while the scoreboard holds any.
  initial begin
    exp_t e;
    forever begin
      @(posedge CK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, dut_outs(), exp_outs(e));
      end
    end
  end

  // Drive one D sample and queue what the outputs must be after that edge.
  task automatic step(input logic d, input logic q, input logic b,
                      input logic r, input logic f, input string tag);
    exp_t e;
    D = d;
    e.q = q; e.b = b; e.r = r; e.f = f; e.tag = tag;
    sb.push_back(e);
    @(negedge CK);
  endtask

  // Assert reset at a negedge, check the asynchronous clear, release one cycle later.
  task automatic do_reset(input logic d, input string tag);
    D = d;
    R = 1'b1;
    #1;
    chk(tag, dut_outs(), 4'b0000);
    @(negedge CK);
    R = 1'b0;
  endtask

  // Reset, then D=1 held: Q rises after edge 7, BUSY after edges 3..6.
  task automatic rise_run(input string pfx);
    for (int k = 1; k <= 9; k++) begin
      logic q, b, r;
      q = (k >= 7);
      b = (k >= 3 && k <= 6);
      r = (k == 7);
      step(1'b1, q, b, r, 1'b0, $sformatf("%s_e%0d", pfx, k));
    end
  endtask

  initial begin
    @(negedge CK);
    do_reset(1'b0, "reset_state");

    rise_run("rise");

    // Q=1 stable, D low held: Q falls after edge 7, FALL pulses once.
    for (int k = 1; k <= 8; k++)
      step(1'b0, (k < 7), (k >= 3 && k <= 6), 1'b0, (k == 7),
           $sformatf("fall_e%0d", k));

    // D high for only 4 samples: qualification aborts, Q stays 0.
    for (int k = 1; k <= 8; k++)
      step((k <= 4), 1'b0, (k >= 3 && k <= 6), 1'b0, 1'b0,
           $sformatf("short_e%0d", k));

    // D toggling every cycle: BUSY follows the 2-cycle-old sample, Q stays 0.
    for (int k = 1; k <= 52; k++) begin
      logic d, b;
      d = (k <= 50) ? logic'(k % 2) : 1'b0;
      b = (k >= 3) && (k % 2 == 1);
      step(d, 1'b0, b, 1'b0, 1'b0, $sformatf("toggle_e%0d", k));
    end

    // Reset mid-count with D high, then requalify from scratch.
    do_reset(1'b0, "reset2");
    for (int k = 1; k <= 4; k++)
      step(1'b1, 1'b0, (k >= 3), 1'b0, 1'b0, $sformatf("midcnt_e%0d", k));
    do_reset(1'b1, "reset_midcount");
    rise_run("rerise");

    @(negedge CK);
    @(negedge CK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
